// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit for the MIPS EX stage.
// Fixed-latency multiply, 34-cycle restoring divide, MTHI/MTLO.
module hilo_muldiv #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  localparam logic [5:0] MulLast = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLast = 6'd33;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic        nq_q, nq_d;
  logic        nr_q, nr_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic        a_neg, b_neg;
  logic [63:0] ma, mb, prod;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;

  assign accept = start & ~flush & (state_q == S_IDLE);

  assign a_neg = sgn_q & opa_q[31];
  assign b_neg = sgn_q & opb_q[31];
  assign ma    = {{32{a_neg}}, opa_q};
  assign mb    = {{32{b_neg}}, opb_q};
  assign prod  = ma * mb;

  assign a_mag = a_neg ? -opa_q : opa_q;
  assign b_mag = b_neg ? -opb_q : opb_q;

  // opb_q holds the divisor magnitude once setup has run
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            unique case (op)
              3'b000, 3'b001: begin
                state_d = S_MUL;
                cnt_d   = '0;
                opa_d   = rs_data;
                opb_d   = rt_data;
                sgn_d   = ~op[0];
              end
              3'b010, 3'b011: begin
                state_d = S_DIV;
                cnt_d   = '0;
                opa_d   = rs_data;
                opb_d   = rt_data;
                sgn_d   = ~op[0];
              end
              3'b100: begin
                hi_d   = rs_data;
                done_d = 1'b1;
              end
              3'b101: begin
                lo_d   = rs_data;
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == MulLast) begin
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_DIV: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd0) begin
            quo_d = a_mag;
            rem_d = '0;
            opb_d = b_mag;
            nq_d  = a_neg ^ b_neg;
            nr_d  = a_neg;
          end else if (cnt_q == DivLast) begin
            if (opb_q == '0) begin
              lo_d = 32'hFFFF_FFFF;
              hi_d = opa_q;
            end else begin
              lo_d = nq_q ? -quo_q : quo_q;
              hi_d = nr_q ? -rem_q : rem_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            if (!diff[32]) begin
              rem_d = diff[31:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = rem_sh[31:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide unit with architectural HI/LO registers for the MIPS pipeline EX stage. It sits directly downstream of the general-purpose register file and takes its two read-port values (rs, rt) as operands. It executes MULT/MULTU in a fixed number of cycles and DIV/DIVU iteratively. It also services MTHI/MTLO and exposes HI/LO for MFHI/MFLO. While busy it asserts a stall so the issue logic holds further mult/div/HI/LO instructions.

## Interface
- MUL_CYCLES, 3, multiply latency in cycles from accept to result; legal range 1..8

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request; sampled on clk rising edge
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (no-op)
- rs_data  in  32  operand A / dividend / MTHI-MTLO source (register file read port 1)
- rt_data  in  32  operand B / divisor (register file read port 2)
- flush  in  1  abort the in-flight MULT/DIV; HI/LO keep old values
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight; upstream must stall HI/LO users
- done  out  1  one-cycle pulse on the cycle HI/LO first show a new result

## Operation
- The unit accepts a request on the edge where start=1, busy=0 and flush=0. The unit ignores start while busy=1: no state change and no error.
- Operands rs_data/rt_data are captured at the accept edge. Later changes to the inputs have no effect.
- States: IDLE, MUL, DIV. Transitions on an accepted MULT/MULTU go IDLE→MUL, and on an accepted DIV/DIVU go IDLE→DIV. Both return to IDLE when the result is written or on flush.
- MTHI/MTLO: HI (or LO) takes rs_data at the accept edge. The other register is unchanged. busy is not raised. done pulses in the following cycle.
- MULT: signed 32×32→64; MULTU: unsigned. HI gets product[63:32] and LO gets product[31:0].
- DIV/DIVU: restoring divider, one quotient bit per cycle, on 32-bit magnitudes.
  - LO = quotient and HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed operands use absolute values internally, with sign fixup in the final cycle.
- Divide by zero (rt_data=0, DIV or DIVU): LO=0xFFFFFFFF, HI=rs_data. Full latency still applies.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
- Reserved op with start=1: ignored, same as no request.
- flush while busy returns the unit to IDLE on that edge. busy drops, done is not pulsed and HI/LO are unchanged. flush while idle has no effect. flush has priority over start on the same edge.
- Reset (async, any state, including mid-divide): hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0.

## Timing
- Accept edge is t0. L = MUL_CYCLES for multiply and L = 34 for divide (1 setup/abs, 32 iterations, 1 fixup).
- busy=1 after edge t0 through edge t0+L. It is deasserted after edge t0+L.
- HI/LO update at edge t0+L. done=1 for exactly the cycle after edge t0+L.
- A new start may be accepted at edge t0+L+1, which is the first edge where busy=0 is sampled. There are no back-to-back accepts during busy.
- MTHI/MTLO: update at t0, done high for the cycle after t0, busy stays 0. A following request can be accepted at t0+1.
- hi/lo are registered outputs. No combinational path exists from start/op/rs_data/rt_data to hi/lo/busy/done.

## Test plan
- Reset check: assert rst_n=0 mid-DIV (cycle 10). Then hi=lo=0 and busy=done=0 immediately, with no done afterwards.
- MULT with rs=0xFFFFFFFF, rt=0x00000002 gives HI=0xFFFFFFFF, LO=0xFFFFFFFE at t0+3. Same operands with MULTU give HI=0x00000001, LO=0xFFFFFFFE. busy is high for exactly 3 cycles.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF at t0+34. DIVU 100/7 gives LO=0x0000000E, HI=0x00000002.
- Corner divides:
  - DIVU 0x1234/0 gives LO=0xFFFFFFFF, HI=0x00001234.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Both cases have 34-cycle latency.
- Flush and busy hold-off:
  - Preload with MTHI 0xAAAA0000 and MTLO 0x5555.
  - Start DIV, then flush at cycle 5. HI/LO stay 0xAAAA0000/0x5555, done never pulses, busy=0 the next cycle.
  - A start asserted during busy is ignored.
- Boundary latency: with MUL_CYCLES=1, MULT 3×5 gives LO=15, HI=0 one edge after accept. A second MULT issued with start held high is accepted at t0+2.
